tlcd_bus_arbiter: RTL

Shares the single Text LCD pin bus between two independent drivers: requester 0 (custom font loader) and requester 1 (text string controller). Replaces the static `font_loader_done` output mux with a request/grant handshake. Adds a guaranteed idle guard interval between owners and round-robin fairness, so further LCD clients can be added without bus contention. Sits directly in front of the TLCD_* top-level pins.

---
 rtl/tlcd_bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tlcd_bus_arbiter.sv
// Round-robin request/grant arbiter sharing the Text LCD pin bus between two drivers,
// with a fixed idle guard interval between owners. Define TLCD_ARB_TIMEOUT_EN for grant timeouts.
module tlcd_bus_arbiter #(
  parameter int          GUARD_CYCLES = 4,
  parameter logic [23:0] MAX_HOLD     = 24'd2_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       E0,
  input  logic       RS0,
  input  logic       RW0,
  input  logic [7:0] DATA0,
  input  logic       E1,
  input  logic       RS1,
  input  logic       RW1,
  input  logic [7:0] DATA1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA,
  output logic       BUSY,
  output logic       TIMEOUT_ERR
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GUARD} state_t;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_bus_t;

  state_t     state, next_state;
  logic       last, next_last;
  logic [7:0] guard_cnt, next_guard_cnt;
  logic [1:0] req_eff;
  logic       owner_req;
  logic       hold_expired;
  logic       timeout_hit;
  lcd_bus_t   bus0, bus1, next_bus;

  assign bus0      = '{e: E0, rs: RS0, rw: RW0, data: DATA0};
  assign bus1      = '{e: E1, rs: RS1, rw: RW1, data: DATA1};
  assign owner_req = (state == GRANT1) ? REQ1 : REQ0;

  param_legal: assert property (@(posedge CLK)
    (MAX_HOLD != 24'd0) && (GUARD_CYCLES >= 1) && (GUARD_CYCLES <= 255));

`ifdef TLCD_ARB_TIMEOUT_EN
  logic [23:0] hold_cnt;
  logic [1:0]  mask;

  assign hold_expired = (hold_cnt == MAX_HOLD - 24'd1);
  assign req_eff      = {REQ1, REQ0} & ~mask;

  // A timed-out requester stays masked until it has dropped REQ for a cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt    <= '0;
      mask        <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT0 || state == GRANT1) ? hold_cnt + 24'd1 : '0;
      if (timeout_hit) begin
        TIMEOUT_ERR <= 1'b1;
        mask[state == GRANT1] <= 1'b1;
      end
      if (!REQ0) mask[0] <= 1'b0;
      if (!REQ1) mask[1] <= 1'b0;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign req_eff      = {REQ1, REQ0};
  assign TIMEOUT_ERR  = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state     = state;
    next_last      = last;
    next_guard_cnt = guard_cnt;
    timeout_hit    = 1'b0;
    next_bus       = '0;

    case (state)
      IDLE: begin
        if (req_eff == 2'b11) begin
          next_state = last ? GRANT0 : GRANT1;
          next_last  = ~last;
        end else if (req_eff[0]) begin
          next_state = GRANT0;
          next_last  = 1'b0;
        end else if (req_eff[1]) begin
          next_state = GRANT1;
          next_last  = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        // A plain release takes precedence over a simultaneous timeout.
        if (!owner_req || hold_expired) begin
          next_state     = GUARD;
          next_guard_cnt = 8'(GUARD_CYCLES - 1);
          timeout_hit    = owner_req;
        end else begin
          next_bus = (state == GRANT1) ? bus1 : bus0;
        end
      end
      GUARD: begin
        if (guard_cnt == 8'd0) next_state = IDLE;
        else                   next_guard_cnt = guard_cnt - 8'd1;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last      <= 1'b1;
      guard_cnt <= '0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      BUSY      <= 1'b0;
      TLCD_E    <= 1'b0;
      TLCD_RS   <= 1'b0;
      TLCD_RW   <= 1'b0;
      TLCD_DATA <= '0;
    end else begin
      state     <= next_state;
      last      <= next_last;
      guard_cnt <= next_guard_cnt;
      GNT0      <= (next_state == GRANT0);
      GNT1      <= (next_state == GRANT1);
      BUSY      <= (next_state != IDLE);
      TLCD_E    <= next_bus.e;
      TLCD_RS   <= next_bus.rs;
      TLCD_RW   <= next_bus.rw;
      TLCD_DATA <= next_bus.data;
    end
  end

endmodule
